// File: rtl/mmio_port_responder.sv
// mmio_port_responder
//   Target side of the core's MEM-stage load/store bus. Decodes a 32-byte
//   register window at BASE_ADDR and owns the output port register, a
//   synchronized input port with sticky rising-edge flags, and a prescaled
//   down-counting timer whose done flag drives TimerIrq.
//
//   Bus semantics: MemRead and MemWrite are single-cycle strobes with no
//   back-pressure. A load returns ReadData combinationally in the same cycle
//   as MemRead&Hit. A store commits at the rising edge that ends the
//   MemWrite&Hit cycle. When both strobes are high, the read shows the
//   pre-write value. There is no ready signal; every hit completes in one cycle.
//
// Ports
//   clk, reset           clock and synchronous active-high reset
//   MemRead, MemWrite    load/store strobes
//   Address, WriteData   byte address and store data
//   PortIn[7:0]          asynchronous input pins
//   ReadData[31:0]       load data, 0 unless MemRead&Hit
//   Hit                  access decodes to this window (word aligned only)
//   PortOut[31:0]        output port register
//   TimerIrq             timer done flag
//
// Register map (offset = Address[4:2])
//   0 PORT_OUT RW | 1 PORT_IN RO | 2 IN_EDGE W1C | 3 TIMER_CTRL {done,auto,en}
//   4 TIMER_LOAD RW (write also loads COUNT) | 5 TIMER_COUNT RO | 6,7 reserved
module mmio_port_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h1001_FFE0,
  parameter int          PRESCALE  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic [7:0]  PortIn,
  output logic [31:0] ReadData,
  output logic        Hit,
  output logic [31:0] PortOut,
  output logic        TimerIrq
);

  localparam int            PW            = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESCALE_LAST = PW'(PRESCALE - 1);

  // State
  logic [31:0]   portOutReg;
  logic [7:0]    s1;
  logic [7:0]    syncIn;
  logic [7:0]    prevIn;
  logic [7:0]    inEdge;
  logic          timerEn;
  logic          timerAuto;
  logic          timerDone;
  logic [31:0]   timerLoad;
  logic [31:0]   timerCount;
  logic [PW-1:0] prescaleCnt;

  // Decode
  logic [2:0] offset;
  logic       wrEn;
  logic       wrPortOut;
  logic       wrInEdge;
  logic       wrCtrl;
  logic       wrLoad;

  assign offset    = Address[4:2];
  assign Hit       = (MemRead | MemWrite)
                   & (Address[31:5] == BASE_ADDR[31:5])
                   & (Address[1:0] == 2'b00);
  assign wrEn      = MemWrite & Hit;
  assign wrPortOut = wrEn & (offset == 3'd0);
  assign wrInEdge  = wrEn & (offset == 3'd2);
  assign wrCtrl    = wrEn & (offset == 3'd3);
  assign wrLoad    = wrEn & (offset == 3'd4);

  // Read mux
  logic [31:0] readVal;

  always_comb begin
    readVal = '0;
    case (offset)
      3'd0:    readVal = portOutReg;
      3'd1:    readVal = {24'b0, syncIn};
      3'd2:    readVal = {24'b0, inEdge};
      3'd3:    readVal = {29'b0, timerDone, timerAuto, timerEn};
      3'd4:    readVal = timerLoad;
      3'd5:    readVal = timerCount;
      default: readVal = '0;
    endcase
  end

  assign ReadData = (MemRead & Hit) ? readVal : '0;
  assign PortOut  = portOutReg;
  assign TimerIrq = timerDone;

  // Next-state logic
  logic [7:0]    edgeSet;
  logic [7:0]    inEdgeNext;
  logic          timerRun;
  logic          timerTick;
  logic          timerExpire;
  logic [PW-1:0] prescaleNext;
  logic [31:0]   countNext;
  logic          doneNext;

  always_comb begin
    edgeSet    = syncIn & ~prevIn;
    // Clear first, then OR in new edges so a coincident edge wins.
    inEdgeNext = inEdge;
    if (wrInEdge) inEdgeNext = inEdge & ~WriteData[7:0];
    inEdgeNext = inEdgeNext | edgeSet;

    // The timer only runs while enabled and non-zero; at zero it idles.
    timerRun    = timerEn && (timerCount != 32'd0);
    timerTick   = timerRun && (prescaleCnt == PRESCALE_LAST);
    timerExpire = timerTick && (timerCount == 32'd1);

    prescaleNext = '0;
    if (!wrLoad && timerRun && !timerTick) prescaleNext = prescaleCnt + 1'b1;

    // A LOAD write overrides any decrement in the same cycle.
    countNext = timerCount;
    if (wrLoad)           countNext = WriteData;
    else if (timerExpire) countNext = timerAuto ? timerLoad : 32'd0;
    else if (timerTick)   countNext = timerCount - 32'd1;

    // Expiry wins over a coincident W1C of done.
    doneNext = timerDone;
    if (wrCtrl && WriteData[2]) doneNext = 1'b0;
    if (timerExpire)            doneNext = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      portOutReg  <= '0;
      s1          <= '0;
      syncIn      <= '0;
      prevIn      <= '0;
      inEdge      <= '0;
      timerEn     <= 1'b0;
      timerAuto   <= 1'b0;
      timerDone   <= 1'b0;
      timerLoad   <= '0;
      timerCount  <= '0;
      prescaleCnt <= '0;
    end else begin
      s1          <= PortIn;
      syncIn      <= s1;
      prevIn      <= syncIn;
      inEdge      <= inEdgeNext;
      timerDone   <= doneNext;
      timerCount  <= countNext;
      prescaleCnt <= prescaleNext;
      if (wrPortOut) portOutReg <= WriteData;
      if (wrLoad)    timerLoad  <= WriteData;
      if (wrCtrl) begin
        timerEn   <= WriteData[0];
        timerAuto <= WriteData[1];
      end
    end
  end

endmodule

// File: tb/tb_mmio_port_responder.sv
// Testbench for mmio_port_responder: register access, input sync and edge
// flags, one-shot and autoreload timer, and reset during operation.
module tb_mmio_port_responder;

  localparam logic [31:0] BASE       = 32'h1001_FFE0;
  localparam logic [31:0] A_PORT_OUT = BASE + 32'h00;
  localparam logic [31:0] A_PORT_IN  = BASE + 32'h04;
  localparam logic [31:0] A_IN_EDGE  = BASE + 32'h08;
  localparam logic [31:0] A_CTRL     = BASE + 32'h0C;
  localparam logic [31:0] A_LOAD     = BASE + 32'h10;
  localparam logic [31:0] A_COUNT    = BASE + 32'h14;
  localparam logic [31:0] A_RSVD     = BASE + 32'h18;

  // Clock / reset
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] Address = '0;
  logic [31:0] WriteData = '0;
  logic [7:0]  PortIn = '0;
  logic [31:0] ReadData;
  logic        Hit;
  logic [31:0] PortOut;
  logic        TimerIrq;

  always #5 clk = ~clk;

  mmio_port_responder #(.BASE_ADDR(BASE), .PRESCALE(4)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Address(Address), .WriteData(WriteData), .PortIn(PortIn),
    .ReadData(ReadData), .Hit(Hit), .PortOut(PortOut), .TimerIrq(TimerIrq)
  );

  // Scoreboard
  logic [31:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // Driver tasks: all stimulus changes 1 time unit after a rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    Address = a; WriteData = d; MemWrite = 1'b1;
    step(1);
    MemWrite = 1'b0; WriteData = '0; Address = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] rd, output logic h);
    Address = a; MemRead = 1'b1;
    #1;
    rd = ReadData; h = Hit;
    MemRead = 1'b0; Address = '0;
  endtask

  task automatic test_reset;
    logic [31:0] rd, exp;
    logic h;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    Address = A_PORT_OUT;
    #1;
    exp_q.push_back(32'd0);
    exp = exp_q.pop_front(); n_cmp++;
    if (PortOut !== exp) begin n_err++; $display("FAIL reset_port_out: got %h want %h", PortOut, exp); end
    exp_q.push_back(32'd0);
    exp = exp_q.pop_front(); n_cmp++;
    if (32'(TimerIrq) !== exp) begin n_err++; $display("FAIL reset_irq: got %h want %h", TimerIrq, exp); end
    exp_q.push_back(32'd0);
    exp = exp_q.pop_front(); n_cmp++;
    if (ReadData !== exp) begin n_err++; $display("FAIL idle_read_data: got %h want %h", ReadData, exp); end
    exp_q.push_back(32'd0);
    exp = exp_q.pop_front(); n_cmp++;
    if (32'(Hit) !== exp) begin n_err++; $display("FAIL idle_hit: got %h want %h", Hit, exp); end
    Address = '0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      exp_q.push_back(32'd0);
      bus_read(BASE + 32'(i * 4), rd, h);
      exp = exp_q.pop_front(); n_cmp++;
      if (rd !== exp) begin n_err++; $display("FAIL reset_reg%0d: got %h want %h", i, rd, exp); end
    end
  endtask

  task automatic test_port;
    logic [31:0] rd, exp;
    logic h;
    step(1);
    bus_write(A_PORT_OUT, 32'hDEAD_BEEF);
    exp_q.push_back(32'hDEAD_BEEF);
    exp = exp_q.pop_front(); n_cmp++;
    if (PortOut !== exp) begin n_err++; $display("FAIL port_out_write: got %h want %h", PortOut, exp); end
    exp_q.push_back(32'hDEAD_BEEF);
    exp_q.push_back(32'd1);
    bus_read(A_PORT_OUT, rd, h);
    exp = exp_q.pop_front(); n_cmp++;
    if (rd !== exp) begin n_err++; $display("FAIL port_out_read: got %h want %h", rd, exp); end
    exp = exp_q.pop_front(); n_cmp++;
    if (32'(h) !== exp) begin n_err++; $display("FAIL port_hit: got %h want %h", h, exp); end
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    bus_read(BASE + 32'h2, rd, h);
    exp = exp_q.pop_front(); n_cmp++;
    if (32'(h) !== exp) begin n_err++; $display("FAIL misaligned_hit: got %h want %h", h, exp); end
    exp = exp_q.pop_front(); n_cmp++;
    if (rd !== exp) begin n_err++; $display("FAIL misaligned_data: got %h want %h", rd, exp); end
    exp_q.push_back(32'd0);
    bus_read(BASE + 32'h20, rd, h);
    exp = exp_q.pop_front(); n_cmp++;
    if (32'(h) !== exp) begin n_err++; $display("FAIL outside_hit: got %h want %h", h, exp); end
    // Simultaneous load and store: read sees the old value.
    step(1);
    Address = A_PORT_OUT; WriteData = 32'h1234_5678; MemRead = 1'b1; MemWrite = 1'b1;
    #1;
    exp_q.push_back(32'hDEAD_BEEF);
    exp = exp_q.pop_front(); n_cmp++;
    if (ReadData !== exp) begin n_err++; $display("FAIL rw_pre_value: got %h want %h", ReadData, exp); end
    step(1);
    MemRead = 1'b0; MemWrite = 1'b0; Address = '0; WriteData = '0;
    exp_q.push_back(32'h1234_5678);
    exp = exp_q.pop_front(); n_cmp++;
    if (PortOut !== exp) begin n_err++; $display("FAIL rw_commit: got %h want %h", PortOut, exp); end
    bus_write(BASE + 32'h1, 32'h0);
    exp_q.push_back(32'h1234_5678);
    exp = exp_q.pop_front(); n_cmp++;
    if (PortOut !== exp) begin n_err++; $display("FAIL misaligned_write: got %h want %h", PortOut, exp); end
    bus_write(A_RSVD, 32'hFFFF_FFFF);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd1);
    bus_read(A_RSVD, rd, h);
    exp = exp_q.pop_front(); n_cmp++;
    if (rd !== exp) begin n_err++; $display("FAIL reserved_data: got %h want %h", rd, exp); end
    exp = exp_q.pop_front(); n_cmp++;
    if (32'(h) !== exp) begin n_err++; $display("FAIL reserved_hit: got %h want %h", h, exp); end
  endtask

  task automatic test_input_edge;
    logic [31:0] rd, exp;
    logic h;
    step(1);
    PortIn = 8'h05;
    step(1);
    exp_q.push_back(32'h00);
    bus_read(A_PORT_IN, rd, h);
    exp = exp_q.pop_front(); n_cmp++;
    if (rd !== exp) begin n_err++; $display("FAIL port_in_1cyc: got %h want %h", rd, exp); end
    step(1);
    exp_q.push_back(32'h05);
    exp_q.push_back(32'h00);
    bus_read(A_PORT_IN, rd, h);
    exp = exp_q.pop_front(); n_cmp++;
    if (rd !== exp) begin n_err++; $display("FAIL port_in_2cyc: got %h want %h", rd, exp); end
    bus_read(A_IN_EDGE, rd, h);
    exp = exp_q.pop_front(); n_cmp++;
    if (rd !== exp) begin n_err++; $display("FAIL in_edge_2cyc: got %h want %h", rd, exp); end
    step(1);
    exp_q.push_back(32'h05);
    bus_read(A_IN_EDGE, rd, h);
    exp = exp_q.pop_front(); n_cmp++;
    if (rd !== exp) begin n_err++; $display("FAIL in_edge_3cyc: got %h want %h", rd, exp); end
    bus_write(A_IN_EDGE, 32'h01);
    exp_q.push_back(32'h04);
    bus_read(A_IN_EDGE, rd, h);
    exp = exp_q.pop_front(); n_cmp++;
    if (rd !== exp) begin n_err++; $display("FAIL in_edge_w1c: got %h want %h", rd, exp); end
    // Bit 0 falls, then re-rises so its edge lands in the W1C cycle.
    PortIn = 8'h04;
    step(3);
    PortIn = 8'h05;
    step(2);
    bus_write(A_IN_EDGE, 32'h01);
    exp_q.push_back(32'h05);
    bus_read(A_IN_EDGE, rd, h);
    exp = exp_q.pop_front(); n_cmp++;
    if (rd !== exp) begin n_err++; $display("FAIL in_edge_set_wins: got %h want %h", rd, exp); end
    bus_write(A_IN_EDGE, 32'h05);
    exp_q.push_back(32'h00);
    bus_read(A_IN_EDGE, rd, h);
    exp = exp_q.pop_front(); n_cmp++;
    if (rd !== exp) begin n_err++; $display("FAIL in_edge_clear_all: got %h want %h", rd, exp); end
  endtask

  task automatic test_oneshot;
    logic [31:0] rd, exp, exp_cnt;
    logic h;
    step(1);
    bus_write(A_LOAD, 32'd3);
    bus_write(A_CTRL, 32'h1);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) step(1);
      exp_cnt = (k < 4) ? 32'd3 : (k < 8) ? 32'd2 : (k < 12) ? 32'd1 : 32'd0;
      exp_q.push_back(exp_cnt);
      exp_q.push_back((k >= 12) ? 32'd1 : 32'd0);
      bus_read(A_COUNT, rd, h);
      exp = exp_q.pop_front(); n_cmp++;
      if (rd !== exp) begin n_err++; $display("FAIL oneshot_count k=%0d: got %h want %h", k, rd, exp); end
      exp = exp_q.pop_front(); n_cmp++;
      if (32'(TimerIrq) !== exp) begin n_err++; $display("FAIL oneshot_irq k=%0d: got %h want %h", k, TimerIrq, exp); end
    end
    exp_q.push_back(32'h5);
    bus_read(A_CTRL, rd, h);
    exp = exp_q.pop_front(); n_cmp++;
    if (rd !== exp) begin n_err++; $display("FAIL oneshot_ctrl_done: got %h want %h", rd, exp); end
    bus_write(A_CTRL, 32'h5);
    exp_q.push_back(32'h1);
    bus_read(A_CTRL, rd, h);
    exp = exp_q.pop_front(); n_cmp++;
    if (rd !== exp) begin n_err++; $display("FAIL oneshot_ctrl_clear: got %h want %h", rd, exp); end
    step(6);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    bus_read(A_COUNT, rd, h);
    exp = exp_q.pop_front(); n_cmp++;
    if (rd !== exp) begin n_err++; $display("FAIL idle_count: got %h want %h", rd, exp); end
    exp = exp_q.pop_front(); n_cmp++;
    if (32'(TimerIrq) !== exp) begin n_err++; $display("FAIL idle_irq: got %h want %h", TimerIrq, exp); end
  endtask

  task automatic test_autoreload;
    logic [31:0] rd, exp;
    logic h;
    step(1);
    bus_write(A_CTRL, 32'h0);
    bus_write(A_LOAD, 32'd2);
    bus_write(A_CTRL, 32'h3);
    for (int k = 0; k < 18; k++) begin
      if (k > 0) step(1);
      exp_q.push_back((((k / 4) % 2) == 0) ? 32'd2 : 32'd1);
      exp_q.push_back((k >= 8) ? 32'd1 : 32'd0);
      bus_read(A_COUNT, rd, h);
      exp = exp_q.pop_front(); n_cmp++;
      if (rd !== exp) begin n_err++; $display("FAIL auto_count k=%0d: got %h want %h", k, rd, exp); end
      exp = exp_q.pop_front(); n_cmp++;
      if (32'(TimerIrq) !== exp) begin n_err++; $display("FAIL auto_irq k=%0d: got %h want %h", k, TimerIrq, exp); end
    end
    // Next decrement lands at the third edge from here; the LOAD write commits on it.
    step(2);
    bus_write(A_LOAD, 32'd9);
    exp_q.push_back(32'd9);
    bus_read(A_COUNT, rd, h);
    exp = exp_q.pop_front(); n_cmp++;
    if (rd !== exp) begin n_err++; $display("FAIL load_wins: got %h want %h", rd, exp); end
    step(3);
    exp_q.push_back(32'd9);
    bus_read(A_COUNT, rd, h);
    exp = exp_q.pop_front(); n_cmp++;
    if (rd !== exp) begin n_err++; $display("FAIL load_prescale_clr: got %h want %h", rd, exp); end
    step(1);
    exp_q.push_back(32'd8);
    bus_read(A_COUNT, rd, h);
    exp = exp_q.pop_front(); n_cmp++;
    if (rd !== exp) begin n_err++; $display("FAIL load_then_dec: got %h want %h", rd, exp); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd, exp;
    logic h;
    step(1);
    bus_write(A_CTRL, 32'h0);
    bus_write(A_PORT_OUT, 32'hFF);
    bus_write(A_LOAD, 32'd5);
    bus_write(A_CTRL, 32'h1);
    PortIn = 8'hAA;
    step(2);
    exp_q.push_back(32'd5);
    exp_q.push_back(32'd1);
    bus_read(A_COUNT, rd, h);
    exp = exp_q.pop_front(); n_cmp++;
    if (rd !== exp) begin n_err++; $display("FAIL pre_reset_count: got %h want %h", rd, exp); end
    exp = exp_q.pop_front(); n_cmp++;
    if (32'(TimerIrq) !== exp) begin n_err++; $display("FAIL pre_reset_irq: got %h want %h", TimerIrq, exp); end
    reset = 1'b1;
    step(1);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    exp = exp_q.pop_front(); n_cmp++;
    if (PortOut !== exp) begin n_err++; $display("FAIL mid_reset_port_out: got %h want %h", PortOut, exp); end
    exp = exp_q.pop_front(); n_cmp++;
    if (32'(TimerIrq) !== exp) begin n_err++; $display("FAIL mid_reset_irq: got %h want %h", TimerIrq, exp); end
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(32'd0);
      bus_read(BASE + 32'(i * 4), rd, h);
      exp = exp_q.pop_front(); n_cmp++;
      if (rd !== exp) begin n_err++; $display("FAIL mid_reset_reg%0d: got %h want %h", i, rd, exp); end
      step(1);
    end
    PortIn = 8'h00;
    reset = 1'b0;
    step(1);
  endtask

  initial begin
    test_reset();
    test_port();
    test_input_edge();
    test_oneshot();
    test_autoreload();
    test_reset_mid();
    if (exp_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mmio_port_responder.md
Name: mmio_port_responder

Overview:
- Memory-mapped I/O responder on the processor's MEM-stage data bus: the target side of the load/store accesses the core issues.
- Decodes a small register window and owns the PortOut register, a synchronized PortIn with sticky edge flags, and a down-counting timer with an interrupt flag.
- The top level muxes ReadData against data RAM using Hit.

Parameters:
- BASE_ADDR, 32'h1001_FFE0, byte address of register window (must be 32-byte aligned)
- PRESCALE, 4, clock cycles per timer decrement (>=1)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- MemRead  input  1  load strobe from EX/MEM control
- MemWrite  input  1  store strobe from EX/MEM control
- Address  input  32  byte address (ALU result, un-offset)
- WriteData  input  32  store data
- PortIn  input  8  asynchronous external input pins
- ReadData  output  32  load data (combinational from registers)
- Hit  output  1  access targets this window
- PortOut  output  32  external output port register
- TimerIrq  output  1  equals TIMER_CTRL.done

Behaviour:
- Interface: one clock `clk`; `reset` is synchronous and active-high. All state updates on the rising edge of `clk`. Reset clears every register, so PortOut=0, TimerIrq=0 and ReadData=0.
- Decode:
  - Hit = (MemRead|MemWrite) & Address[31:5]==BASE_ADDR[31:5] & Address[1:0]==0.
  - Misaligned accesses give Hit=0 and have no effect.
  - Offsets are Address[4:2].
- Register map:
  - 0x00 PORT_OUT: RW, 32 bits, drives PortOut.
  - 0x04 PORT_IN: RO, {24'b0, sync_in}.
  - 0x08 IN_EDGE: RO bits [7:0]. Each bit is sticky, set on a rising edge of sync_in. Writing 1 clears the bit (W1C); writing 0 leaves it unchanged.
  - 0x0C TIMER_CTRL: bit0 en (RW), bit1 autoreload (RW), bit2 done (W1C). Other bits read 0.
  - 0x10 TIMER_LOAD: RW, 32 bits. A write also loads TIMER_COUNT and clears the prescaler.
  - 0x14 TIMER_COUNT: RO.
  - 0x18 and 0x1C: read 0 with Hit=1; writes are ignored.
- Read timing: ReadData is valid in the same cycle when MemRead&Hit, otherwise 0. With MemRead and MemWrite both high, ReadData shows the pre-write value and the write commits at the edge.
- Write timing: the write takes effect at the rising edge when MemWrite&Hit.
- Input path:
  - Two-flop synchronizer PortIn -> s1 -> sync_in.
  - A prev register holds sync_in from the previous cycle.
  - edge[i] sets when sync_in[i]&~prev[i].
  - PortIn-to-PORT_IN latency is 2 cycles; IN_EDGE sets on the 3rd edge after PortIn rises.
  - If an edge occurs in the same cycle as a W1C of that bit, the bit stays set (set wins).
- Timer prescaler:
  - The prescaler counts 0..PRESCALE-1 while en=1 and COUNT!=0.
  - When it wraps to 0, COUNT decrements by 1.
  - When en=0 the prescaler holds at 0 and COUNT freezes.
- Timer expiry (decrement from 1 to 0):
  - done is set.
  - With autoreload=1, COUNT is loaded with LOAD instead of 0; if LOAD==0 it stays 0.
  - With autoreload=0, COUNT stays 0 and the timer idles with en still 1.
  - If expiry coincides with a W1C of done, done stays set.
  - A LOAD write in the same cycle as a decrement wins: COUNT=new LOAD.
- COUNT=0 with en=1 and no reload: no decrement, no new done.
- Reset asserted mid-countdown returns all state to 0 at the next edge, including the synchronizer flops.
- Unsigned 32-bit arithmetic; no wrap below 0.

Test Plan:
- Reset then idle: assert reset 2 cycles -> PortOut=0, TimerIrq=0, ReadData=0, Hit=0 with no strobes.
- Port write/read: store 0xDEADBEEF to 0x1001FFE0 -> PortOut=0xDEADBEEF next cycle. Load 0x1001FFE0 -> ReadData=0xDEADBEEF, Hit=1. Load 0x1001FFE2 -> Hit=0.
- Input sync/edge: PortIn 0x00->0x05 -> PORT_IN reads 0x05 two cycles later and IN_EDGE reads 0x05 from the 3rd cycle. Write 0x01 to 0x1001FFE8 -> IN_EDGE reads 0x04. Repeat with bit0 re-rising in the W1C cycle -> bit0 remains 1.
- One-shot timer (PRESCALE=4): write LOAD=3, CTRL=0x1 -> COUNT 3,2,1,0 at 4-cycle intervals. TimerIrq=1 exactly 12 cycles after the CTRL write and COUNT holds 0. Write CTRL=0x5 -> done clears, en stays 1.
- Autoreload: LOAD=2, CTRL=0x3 -> COUNT sequence 2,1,2,1,… and done set at the first expiry. A LOAD write of 9 coinciding with a decrement -> COUNT=9.
- Reset mid-operation: reset during a countdown with COUNT=5 and PortOut=0xFF -> all registers 0 after one edge, TimerIrq=0.
